// File: rtl/vram_writer.sv
// Write side of the VGA frame RAM: accepts (x, y, colour) pixel writes and runs a
// whole-frame fill engine, both driving one registered RAM write port.
module vram_writer #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int DW    = 12,
    parameter int AW    = 15,
    parameter int SHIFT = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          px_valid,
    output logic          px_ready,
    input  logic [9:0]    px_x,
    input  logic [8:0]    px_y,
    input  logic [DW-1:0] px_data,
    input  logic          fill_req,
    input  logic [DW-1:0] fill_color,
    output logic          busy,
    output logic          fill_done,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic [7:0]    drop_cnt
);

    localparam int NWORDS = (H_ACT * V_ACT) >> SHIFT;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    localparam logic [9:0]    LP_HACT   = 10'(H_ACT);
    localparam logic [8:0]    LP_VACT   = 9'(V_ACT);
    localparam logic [AW-1:0] LP_NWORDS = AW'(NWORDS);

    logic [0:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic [DW-1:0] r_color;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic          r_done;
    logic [7:0]    r_drop;

    logic [18:0]   w_paddr;
    logic          w_inRange;

    // y*640 + x as two shifted copies of y plus x, no multiplier needed
    assign w_paddr   = {1'b0, px_y, 9'b0} + {3'b0, px_y, 7'b0} + {9'b0, px_x};
    assign w_inRange = (px_x < LP_HACT) && (px_y < LP_VACT);

    assign px_ready  = (r_state == S_IDLE) && !fill_req;
    assign busy      = (r_state == S_FILL);
    assign we        = r_we;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign fill_done = r_done;
    assign drop_cnt  = r_drop;

    // The counter runs one past the last word so the exit edge follows the final write
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_color <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (fill_req) begin
                        r_state <= S_FILL;
                        r_color <= fill_color;
                        r_cnt   <= '0;
                    end else if (px_valid) begin
                        if (w_inRange) begin
                            r_we    <= 1'b1;
                            r_waddr <= AW'(w_paddr >> SHIFT);
                            r_wdata <= px_data;
                        end else if (r_drop != 8'hFF) begin
                            r_drop <= r_drop + 8'd1;
                        end
                    end
                end
                S_FILL: begin
                    if (r_cnt == LP_NWORDS) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_we    <= 1'b1;
                        r_waddr <= r_cnt;
                        r_wdata <= r_color;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: table of pixel vectors plus hand-written
// sequences for saturation, the full fill sweep, fill/pixel collision and reset mid-fill.
module tb_vram_writer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pxValid;
    logic        pxReady;
    logic [9:0]  pxX;
    logic [8:0]  pxY;
    logic [11:0] pxData;
    logic        fillReq;
    logic [11:0] fillColor;
    logic        busy;
    logic        fillDone;
    logic        we;
    logic [14:0] waddr;
    logic [11:0] wdata;
    logic [7:0]  dropCnt;

    int errors = 0;
    int checks = 0;

    vram_writer dut (
        .clk        (clk),
        .rstn       (rstn),
        .px_valid   (pxValid),
        .px_ready   (pxReady),
        .px_x       (pxX),
        .px_y       (pxY),
        .px_data    (pxData),
        .fill_req   (fillReq),
        .fill_color (fillColor),
        .busy       (busy),
        .fill_done  (fillDone),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .drop_cnt   (dropCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [11:0] data;
        logic        expWe;
        logic [14:0] expAddr;
        logic [11:0] expData;
        logic [7:0]  expDrop;
    } vec_t;

    vec_t vecs[7];

    // Compares one observed value against its expected value and records the outcome
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Presents one pixel for a single rising edge, leaving inputs idle afterwards
    task automatic applyStimulus(input logic [9:0] x, input logic [8:0] y, input logic [11:0] d);
        @(negedge clk);
        pxX     = x;
        pxY     = y;
        pxData  = d;
        pxValid = 1'b1;
        @(negedge clk);
        pxValid = 1'b0;
    endtask

    initial begin
        int  wr;
        int  badOrder;
        int  badData;
        int  badReady;
        int  badBusy;
        int  weSeen;
        bit  done;
        bit  hit;

        vecs[0] = '{10'd17,  9'd1,   12'hF00, 1'b1, 15'd41,    12'hF00, 8'd0};
        vecs[1] = '{10'd639, 9'd479, 12'h0AB, 1'b1, 15'd19199, 12'h0AB, 8'd0};
        vecs[2] = '{10'd15,  9'd0,   12'h111, 1'b1, 15'd0,     12'h111, 8'd0};
        vecs[3] = '{10'd16,  9'd0,   12'h222, 1'b1, 15'd1,     12'h222, 8'd0};
        vecs[4] = '{10'd640, 9'd0,   12'h333, 1'b0, 15'd1,     12'h222, 8'd1};
        vecs[5] = '{10'd0,   9'd480, 12'h444, 1'b0, 15'd1,     12'h222, 8'd2};
        vecs[6] = '{10'd100, 9'd200, 12'h5A5, 1'b1, 15'd8006,  12'h5A5, 8'd2};

        rstn      = 1'b0;
        pxValid   = 1'b0;
        pxX       = '0;
        pxY       = '0;
        pxData    = '0;
        fillReq   = 1'b0;
        fillColor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        checkOutput("reset_we", 32'(we), 32'd0);
        checkOutput("reset_waddr", 32'(waddr), 32'd0);
        checkOutput("reset_wdata", 32'(wdata), 32'd0);
        checkOutput("reset_fill_done", 32'(fillDone), 32'd0);
        checkOutput("reset_drop", 32'(dropCnt), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ready", 32'(pxReady), 32'd1);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].data);
            checkOutput($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].expWe));
            checkOutput($sformatf("vec%0d_waddr", i), 32'(waddr), 32'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d_wdata", i), 32'(wdata), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d_drop", i), 32'(dropCnt), 32'(vecs[i].expDrop));
            @(negedge clk);
            checkOutput($sformatf("vec%0d_we_after", i), 32'(we), 32'd0);
        end

        // 300 back-to-back out-of-range pixels drive drop_cnt into saturation
        weSeen = 0;
        @(negedge clk);
        pxX     = 10'd700;
        pxY     = 9'd3;
        pxValid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (we) weSeen++;
        end
        pxValid = 1'b0;
        @(negedge clk);
        checkOutput("sat_we_seen", 32'(weSeen), 32'd0);
        checkOutput("sat_drop", 32'(dropCnt), 32'd255);

        // Fill request collides with a valid in-range pixel on the same edge
        @(negedge clk);
        fillReq   = 1'b1;
        fillColor = 12'h123;
        pxX       = 10'd32;
        pxY       = 9'd0;
        pxData    = 12'hFFF;
        pxValid   = 1'b1;
        #1;
        checkOutput("ready_on_fill_req", 32'(pxReady), 32'd0);
        @(negedge clk);
        fillReq = 1'b0;
        checkOutput("fill_busy_start", 32'(busy), 32'd1);
        checkOutput("fill_we_start", 32'(we), 32'd0);

        wr = 0; badOrder = 0; badData = 0; badReady = 0; badBusy = 0; done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk);
            if (wr == 5000) fillColor = 12'hABC;
            if (fillDone) begin
                done = 1'b1;
            end else begin
                if (!busy) badBusy++;
                if (pxReady) badReady++;
                if (we) begin
                    if (32'(waddr) != wr) badOrder++;
                    if (wdata != 12'h123) badData++;
                    wr++;
                end
            end
        end
        checkOutput("fill_completed", 32'(done), 32'd1);
        checkOutput("fill_write_count", 32'(wr), 32'd19200);
        checkOutput("fill_order_errs", 32'(badOrder), 32'd0);
        checkOutput("fill_data_errs", 32'(badData), 32'd0);
        checkOutput("fill_ready_errs", 32'(badReady), 32'd0);
        checkOutput("fill_busy_errs", 32'(badBusy), 32'd0);
        checkOutput("done_busy", 32'(busy), 32'd0);
        checkOutput("done_we", 32'(we), 32'd0);
        checkOutput("done_ready", 32'(pxReady), 32'd1);
        checkOutput("done_last_waddr", 32'(waddr), 32'd19199);

        // The pixel held valid through the sweep is taken on the fill_done cycle's edge
        @(negedge clk);
        pxValid = 1'b0;
        checkOutput("done_one_cycle", 32'(fillDone), 32'd0);
        checkOutput("held_px_we", 32'(we), 32'd1);
        checkOutput("held_px_waddr", 32'(waddr), 32'd2);
        checkOutput("held_px_wdata", 32'(wdata), 32'hFFF);

        // Reset while the sweep is at word 100 aborts it silently
        @(negedge clk);
        fillReq   = 1'b1;
        fillColor = 12'h0F0;
        @(negedge clk);
        fillReq = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            if (we && waddr == 15'd100) hit = 1'b1;
            else @(negedge clk);
        end
        checkOutput("reached_waddr_100", 32'(hit), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("abort_we", 32'(we), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_waddr", 32'(waddr), 32'd0);
        checkOutput("abort_fill_done", 32'(fillDone), 32'd0);
        checkOutput("abort_drop", 32'(dropCnt), 32'd0);
        rstn = 1'b1;
        #1;
        checkOutput("abort_ready", 32'(pxReady), 32'd1);
        weSeen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (we || fillDone || busy) weSeen++;
        end
        checkOutput("abort_quiet", 32'(weSeen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_writer.md
Name: vram_writer

Overview:
Write-side companion to the VGA frame-RAM read path. Accepts pixel writes as (x, y, colour) over a valid/ready handshake and forms the linear pixel address y*640+x. It drives the RAM write port with word address paddr[18:4], so 16 consecutive pixels share one 12-bit word, matching the display read mapping. Also provides a whole-frame fill/clear engine that sweeps every word of the frame RAM.

Parameters:
H_ACT, 640, active pixels per line
V_ACT, 480, active lines per frame
DW, 12, colour/word width (RGB444)
AW, 15, RAM word-address width
SHIFT, 4, log2(pixels per RAM word); waddr = paddr >> SHIFT
NWORDS, 19200, (H_ACT*V_ACT) >> SHIFT, words swept by fill

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  synchronous active-low reset
px_valid  in  1  pixel write request
px_ready  out  1  block can accept pixel this cycle
px_x  in  10  pixel column
px_y  in  9  pixel row
px_data  in  12  pixel colour
fill_req  in  1  start full-frame fill (level sampled in IDLE)
fill_color  in  12  fill colour, latched when fill starts
busy  out  1  high while fill in progress
fill_done  out  1  one-cycle pulse after last fill write
we  out  1  RAM write enable
waddr  out  15  RAM word address
wdata  out  12  RAM write data
drop_cnt  out  8  count of dropped out-of-range pixels, saturating

Behaviour:
- Reset: synchronous. rstn low at a rising edge sets state=IDLE, we=0, waddr=0, wdata=0, fill_done=0, drop_cnt=0, internal fill counter=0. Applies mid-fill: the sweep is aborted with no fill_done pulse.
- States: IDLE, FILL.
- px_ready = (state==IDLE) && !fill_req. Combinational; does not depend on px_valid.
- Pixel accept: occurs at a rising edge with px_valid && px_ready.
  - In range (px_x < H_ACT and px_y < V_ACT): paddr = px_y*640 + px_x, 19 bits, computed as (y<<9)+(y<<7)+x with no multiplier. On that edge, register we=1, waddr=paddr[18:4], wdata=px_data. Latency is one cycle.
  - Out of range: no write (we=0); drop_cnt increments and saturates at 255.
- Back-to-back accepts give one write per cycle. we is high only in cycles following an accept edge or during FILL; otherwise 0. waddr and wdata hold their last values when we=0.
- IDLE -> FILL: at an edge where fill_req=1. fill_color is latched and the counter cleared. fill_req wins over a simultaneous px_valid; that pixel is not accepted because px_ready=0.
- FILL: each cycle registers we=1, waddr=counter, wdata=latched colour, then increments the counter. Addresses run 0..NWORDS-1 (19199) in strict order, with exactly NWORDS writes. busy=1 for the whole FILL state.
- FILL -> IDLE: on the edge after the write of 19199 is registered. That edge sets we=0 and fill_done=1 for exactly one cycle. px_ready returns high in the same cycle, subject to fill_req.
- fill_req during FILL is ignored (no restart). fill_req held high after completion starts a new fill on the next IDLE edge.
- Changes to fill_color during FILL have no effect.
- Bit widths: waddr is never greater than 19199 for in-range pixels; the maximum paddr is 307199.

Test Plan:
- Reset then pixel (x=17, y=1, data=12'hF00) with px_valid for one edge -> next cycle we=1, waddr=41 (paddr=657), wdata=F00; following cycle we=0.
- Corner pixel (639, 479, 12'h0AB) -> we=1, waddr=19199, wdata=0AB. Pixel (15, 0) -> waddr=0; pixel (16, 0) -> waddr=1.
- Out-of-range pixels (640, 0), then (0, 480), then 300 more invalid pixels -> we never asserted; drop_cnt=1, then 2, then saturates at 255.
- fill_req one cycle with fill_color=12'h123 -> busy high; 19200 consecutive we cycles with waddr 0..19199 and wdata=123; fill_color changed mid-sweep has no effect; px_ready=0 and px_valid ignored throughout; fill_done pulses once in the cycle after waddr=19199 and busy falls with it.
- fill_req and px_valid asserted on the same IDLE edge -> pixel not accepted (px_ready=0 that cycle); fill starts at waddr=0; the pixel is accepted after fill_done if still valid.
- Reset asserted during FILL when waddr=100 -> next edge we=0, busy=0, waddr=0, no fill_done; px_ready=1 after rstn is released.
